// File: rtl/instruction_loader_pkg.sv
// Shared constants for the instruction loader: FSM encoding, word geometry, default end marker.
// Pure declarations; no timing or flow control of its own.
package loader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream in / block-RAM write port out bundle; master drives the stream, slave is the loader.
// Strobe-only stream (no ready): the loader must take a byte every rx_valid cycle.
interface instruction_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              busy;
  logic              done;
  logic              full;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, rx_data, rx_valid,
    input  wea, addra, dina, busy, done, full, word_count
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output wea, addra, dina, busy, done, full, word_count
  );
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word packer; word_vld is combinational with the 4th byte (zero added latency).
// No backpressure: every byte_vld cycle consumes a byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clr) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (byte_vld) begin
      sr_d  = {sr_q[15:0], byte_dat};
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign word_vld = byte_vld && (idx_q == LAST_IDX);
  assign word     = {sr_q, byte_dat};

endmodule

// File: rtl/instruction_loader.sv
// Fills instruction memory from a byte stream; write strobe one cycle after each 4th byte.
// No backpressure; bytes arriving in the final (halt/full) write cycle or outside LOAD are dropped.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input logic               clka,
  input logic               rsta,
  instruction_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE_A     = 1;
  localparam logic [ADDR_W:0]   ONE_C     = 1;

  logic [1:0]        state_q, state_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic        begin_load;
  logic        write_ends;
  logic        byte_take;
  logic        word_vld;
  logic [31:0] word;

  // The write cycle that ends the load also blocks new bytes, so nothing
  // half-assembled survives into DONE.
  always_comb begin
    begin_load = (state_q != ST_LOAD) && bus.start;
    write_ends = wea_q && ((dina_q == HALT_WORD) || (addra_q == LAST_ADDR));
    byte_take  = (state_q == ST_LOAD) && bus.rx_valid && !write_ends;
  end

  byte_packer u_packer (
    .clk      (clka),
    .rst      (rsta),
    .clr      (begin_load),
    .byte_vld (byte_take),
    .byte_dat (bus.rx_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d = state_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    busy_d  = busy_q;
    done_d  = done_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    if (begin_load) begin
      state_d = ST_LOAD;
      addra_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      full_d  = 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (wea_q) begin
        addra_d = addra_q + ONE_A;
        cnt_d   = cnt_q + ONE_C;
      end
      if (write_ends) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        full_d  = (dina_q != HALT_WORD);
      end else if (word_vld) begin
        wea_d  = 1'b1;
        dina_d = DATA_W'(word);
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= ST_IDLE;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wea        = wea_q;
  assign bus.addra      = addra_q;
  assign bus.dina       = dina_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.full       = full_q;
  assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader with a 4-word memory: directed scenarios plus random streams,
// every output checked each cycle against a word-level model of the load rules.
module tb_instruction_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

  instruction_loader #(.ADDR_W(AW), .DATA_W(32), .HALT_WORD(HALT)) dut (
    .clka (clk),
    .rsta (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: mode 0 idle, 1 loading, 2 finished.
  int          mode = 0;
  int          nbytes = 0;
  logic [31:0] acc = '0;
  logic        e_wea = 0, e_busy = 0, e_done = 0, e_full = 0;
  int          e_addr = 0, e_cnt = 0;
  logic [31:0] e_dina = '0;
  bit          model_live = 0;

  initial begin
    bit ending, ends_full, new_wea;
    forever begin
      @(posedge clk);
      if (rst) begin
        mode = 0; nbytes = 0; acc = '0;
        e_wea = 0; e_busy = 0; e_done = 0; e_full = 0;
        e_addr = 0; e_cnt = 0; e_dina = '0;
        model_live = 1;
      end else begin
        ending    = e_wea && (e_dina == HALT || e_addr == DEPTH - 1);
        ends_full = ending && (e_dina != HALT);
        new_wea   = 0;
        if (mode != 1 && bus.start) begin
          mode = 1; nbytes = 0; acc = '0;
          e_addr = 0; e_cnt = 0; e_busy = 1; e_done = 0; e_full = 0;
        end else if (mode == 1) begin
          if (e_wea) begin
            e_addr = (e_addr + 1) % DEPTH;
            e_cnt  = e_cnt + 1;
          end
          if (ending) begin
            mode = 2; e_busy = 0; e_done = 1; e_full = ends_full;
          end else if (bus.rx_valid) begin
            acc    = (acc << 8) | 32'(bus.rx_data);
            nbytes = nbytes + 1;
            if (nbytes == 4) begin
              new_wea = 1; e_dina = acc; nbytes = 0;
            end
          end
        end
        e_wea = new_wea;
      end
    end
  end

  // Image of what the DUT actually wrote, for the literal checks.
  logic [31:0] dmem [DEPTH];
  int          wea_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("wea",        bus.wea,        e_wea);
        chk("addra",      bus.addra,      e_addr);
        chk("dina",       bus.dina,       e_dina);
        chk("busy",       bus.busy,       e_busy);
        chk("done",       bus.done,       e_done);
        chk("full",       bus.full,       e_full);
        chk("word_count", bus.word_count, e_cnt);
        if (bus.wea === 1'b1) begin
          dmem[bus.addra] = bus.dina;
          wea_count++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic clear_image();
    for (int k = 0; k < DEPTH; k++) dmem[k] = '0;
    wea_count = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, bus.done, 1'b1);
    @(negedge clk);
  endtask

  logic [31:0] prog [3];

  initial begin
    int nwords, gap;
    logic [31:0] w;
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h0000_000C;
    prog[2] = 32'hFFFF_FFFF;

    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    rst = 1'b1;
    clear_image();
    repeat (2) @(negedge clk);
    chk("rst_wea",   bus.wea, 0);
    chk("rst_addra", bus.addra, 0);
    chk("rst_dina",  bus.dina, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_full",  bus.full, 0);
    chk("rst_cnt",   bus.word_count, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) send_byte(8'hFF, 0);
    @(negedge clk);
    chk("idle_cnt", bus.word_count, 0);
    chk("idle_writes", wea_count, 0);

    // Basic back-to-back load.
    clear_image();
    pulse_start();
    for (int k = 0; k < 3; k++) send_word(prog[k], 0);
    wait_done("basic_done_wait");
    chk("basic_m0", dmem[0], 32'h2001_0005);
    chk("basic_m1", dmem[1], 32'h0000_000C);
    chk("basic_m2", dmem[2], 32'hFFFF_FFFF);
    chk("basic_busy", bus.busy, 0);
    chk("basic_full", bus.full, 0);
    chk("basic_cnt", bus.word_count, 3);
    chk("basic_writes", wea_count, 3);

    // Same program with three idle cycles between bytes.
    clear_image();
    pulse_start();
    for (int k = 0; k < 3; k++) send_word(prog[k], 3);
    wait_done("gap_done_wait");
    chk("gap_m0", dmem[0], 32'h2001_0005);
    chk("gap_m1", dmem[1], 32'h0000_000C);
    chk("gap_m2", dmem[2], 32'hFFFF_FFFF);
    chk("gap_cnt", bus.word_count, 3);
    chk("gap_writes", wea_count, 3);

    // Fill all four words without a halt marker.
    clear_image();
    pulse_start();
    for (int k = 0; k < 16; k++) send_byte(8'(8'h10 + k), 0);
    wait_done("full_done_wait");
    chk("full_m0", dmem[0], 32'h1011_1213);
    chk("full_m3", dmem[3], 32'h1C1D_1E1F);
    chk("full_flag", bus.full, 1);
    chk("full_cnt", bus.word_count, 4);
    chk("full_addra", bus.addra, 0);
    for (int k = 0; k < 8; k++) send_byte(8'h55, 0);
    repeat (2) @(negedge clk);
    chk("full_no_more_writes", wea_count, 4);

    // Reset in the middle of a word, then restart.
    clear_image();
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", wea_count, 0);
    pulse_start();
    send_word(32'hAABB_CCDD, 0);
    @(negedge clk);
    chk("restart_m0", dmem[0], 32'hAABB_CCDD);
    chk("restart_addra", bus.addra, 1);
    pulse_start();
    chk("start_in_load_addra", bus.addra, 1);
    chk("start_in_load_busy", bus.busy, 1);
    send_word(HALT, 0);
    wait_done("restart_done_wait");
    chk("restart_cnt", bus.word_count, 2);

    // Reload from DONE overwrites from address 0.
    pulse_start();
    chk("reload_done", bus.done, 0);
    chk("reload_addra", bus.addra, 0);
    chk("reload_cnt", bus.word_count, 0);
    send_word(32'h0102_0304, 1);
    send_word(HALT, 0);
    wait_done("reload_done_wait");
    chk("reload_m0", dmem[0], 32'h0102_0304);
    chk("reload_m1", dmem[1], HALT);
    chk("reload_cnt2", bus.word_count, 2);

    // Random programs: halts, fills, partial words, stray starts, resets.
    for (int it = 0; it < 40; it++) begin
      pulse_start();
      nwords = $urandom_range(1, 6);
      for (int n = 0; n < nwords; n++) begin
        w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
        gap = $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0) begin
          send_byte(8'($urandom), gap);
          if ($urandom_range(0, 1) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
          end
          break;
        end
        if ($urandom_range(0, 9) == 0) pulse_start();
        send_word(w, gap);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom), 0);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction-memory block RAM port: fills InstructionMemory from a byte stream (UART receiver or debug host) before the CPU fetches.
- Packs bytes big-endian into 32-bit words and issues one single-cycle write per word at consecutive addresses from 0.
- Stops when it writes the halt word or fills the memory, then reports done.

Parameters:
- ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words.
- DATA_W, 32, instruction word width; fixed at 4 bytes.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is still written to memory.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- rsta  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- rx_data  in  8  incoming program byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- wea  out  1  memory write enable, one cycle per word.
- addra  out  ADDR_W  memory write address.
- dina  out  DATA_W  memory write data.
- busy  out  1  load in progress.
- done  out  1  load finished; held until start or reset.
- full  out  1  load ended because memory filled without a halt word.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset (rsta=1 at a clock edge): state IDLE; wea=0, addra=0, dina=0, busy=0, done=0, full=0, word_count=0, byte index=0. Reset mid-word or mid-write drops the partial word and cancels any write in the next cycle.
- States:
  - IDLE: start -> LOAD. rx_valid is ignored.
  - LOAD: accepts bytes and writes words.
  - DONE: start -> LOAD. rx_valid is ignored.
- Entering LOAD on start at edge T:
  - Clears addra, word_count, byte index, done and full.
  - busy=1 from the cycle after T.
  - A start while in LOAD is ignored.
- Byte accept: in LOAD, each rx_valid cycle takes one byte, regardless of wea.
  - Byte 0 -> word[31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
  - Byte index wraps 3 -> 0.
- Write timing: the 4th byte accepted at edge t produces, in the cycle after t:
  - wea=1 for exactly one cycle;
  - dina = the assembled word;
  - addra = the current write address.
  - At the following edge: addra increments (modulo 2**ADDR_W) and word_count increments.
  - Back-to-back bytes at one per cycle are sustained with no stall and no loss.
- Halt: if the written word equals HALT_WORD, the state goes to DONE at the edge ending the write cycle.
  - busy=0 and done=1 in the next cycle; full=0.
  - Bytes arriving during the halt write cycle are dropped.
- Full: if the written address is 2**ADDR_W-1 and the word is not HALT_WORD:
  - Goes to DONE as for halt, but with full=1.
  - addra wraps to 0; word_count = 2**ADDR_W.
- Partial word: bytes at load end (no 4th byte) are never written; they are discarded on the next start or reset.
- Outputs are registered; dina holds its last value when wea=0.

Decomposition:
- Shared package loader_pkg: state encoding (IDLE/LOAD/DONE), BYTES_PER_WORD=4, default HALT_WORD constant.
- One natural sub-module, byte_packer: shift register plus byte index, emits word_valid and word.
- The loader FSM and address/count logic stay in the top module.

Test Plan:
- Reset value check: hold rsta 2 cycles -> every output 0; rx_valid pulses in IDLE -> no wea, word_count stays 0.
- Basic load: start, then bytes 20 01 00 05 / 00 00 00 0C / FF FF FF FF, one per cycle.
  - Writes in order: addr0=32'h2001_0005, addr1=32'h0000_000C, addr2=32'hFFFF_FFFF, each wea pulse 1 cycle.
  - done=1, busy=0, full=0, word_count=3.
- Gapped bytes: 3 idle cycles between every byte -> same memory image as basic load; wea only the cycle after each 4th byte.
- Full, with ADDR_W=2: start, then 16 non-halt bytes.
  - 4 writes, addr 0..3.
  - done=1, full=1, word_count=4, addra=0.
  - Further bytes cause no wea.
- Reset mid-word and restart:
  - 2 bytes, then rsta -> no write.
  - Restart with start plus 4 bytes AA BB CC DD -> write addr0=32'hAABB_CCDD.
  - start pulsed during LOAD is ignored (addra not cleared).
- Reload after done: start in DONE -> done=0, addra=0, word_count=0; new halt-terminated stream overwrites from address 0.
